// File: rtl/pll_freq_checker.sv
// pll_freq_checker: counts rising edges of an asynchronous PLL-derived signal over a fixed
// CLK gate window, classifies each count against a range and declares lock after a good streak.
module pll_freq_checker #(
   parameter int GATE_CYCLES    = 1000,
   parameter int CNT_W          = 16,
   parameter int EXP_MIN        = 90,
   parameter int EXP_MAX        = 110,
   parameter int LOCK_WINDOWS   = 3,
   parameter int SETTLE_WINDOWS = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             meas_in,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             count_valid,
   output logic             led_ok,
   output logic             led_low,
   output logic             led_high,
   output logic             led_dead,
   output logic             led_hb
);
   localparam int GW = $clog2(GATE_CYCLES);
   localparam int SW = $clog2(SETTLE_WINDOWS + 1);
   localparam int LW = $clog2(LOCK_WINDOWS + 1);
   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE} state_t;
   state_t state, state_nx;
   logic s1, s2, s3, meas_edge, term, report, in_range, sat;
   logic [GW-1:0] gate, gate_nx;
   logic [SW-1:0] settle, settle_nx;
   logic [CNT_W-1:0] ecnt, ecnt_nx, total;
   logic [LW-1:0] streak, streak_nx;
   assign meas_edge = s2 & ~s3;
   always_comb begin
      term      = gate == GW'(GATE_CYCLES - 1);
      total     = (meas_edge && ecnt != '1) ? ecnt + 1'b1 : ecnt;
      sat       = total == '1;
      in_range  = !sat && total >= CNT_W'(EXP_MIN) && total <= CNT_W'(EXP_MAX);
      streak_nx = in_range ? (streak == LW'(LOCK_WINDOWS) ? streak : streak + 1'b1) : '0;
      state_nx  = state;
      gate_nx   = '0;
      settle_nx = settle;
      ecnt_nx   = '0;
      report    = 1'b0;
      if (!enable) begin
         state_nx  = IDLE;
         settle_nx = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx  = SETTLE;
               settle_nx = '0;
            end
            SETTLE: begin
               gate_nx   = term ? '0 : gate + 1'b1;
               settle_nx = term ? settle + 1'b1 : settle;
               state_nx  = (term && settle == SW'(SETTLE_WINDOWS - 1)) ? MEASURE : SETTLE;
            end
            default: begin
               gate_nx = term ? '0 : gate + 1'b1;
               ecnt_nx = term ? '0 : total;
               report  = term;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {s1, s2, s3} <= '0;
         state        <= IDLE;
         gate         <= '0;
         settle       <= '0;
         ecnt         <= '0;
         streak       <= '0;
         count        <= '0;
         count_valid  <= 1'b0;
         led_ok       <= 1'b0;
         led_low      <= 1'b0;
         led_high     <= 1'b0;
         led_dead     <= 1'b0;
         led_hb       <= 1'b0;
      end else begin
         s1          <= meas_in;
         s2          <= s1;
         s3          <= s2;
         state       <= state_nx;
         gate        <= gate_nx;
         settle      <= settle_nx;
         ecnt        <= ecnt_nx;
         count_valid <= report;
         // disabling drops status and streak but keeps the last count and heartbeat phase
         if (!enable) begin
            streak   <= '0;
            led_ok   <= 1'b0;
            led_low  <= 1'b0;
            led_high <= 1'b0;
            led_dead <= 1'b0;
         end else if (report) begin
            count    <= total;
            led_hb   <= ~led_hb;
            streak   <= streak_nx;
            led_ok   <= streak_nx == LW'(LOCK_WINDOWS);
            led_dead <= total == '0;
            led_low  <= total != '0 && total < CNT_W'(EXP_MIN);
            led_high <= sat || total > CNT_W'(EXP_MAX);
         end
      end
   end
endmodule

// File: tb/tb_pll_freq_checker.sv
// tb_pll_freq_checker: scoreboard bench; expected window results are queued as each
// window's stimulus is chosen and compared when the DUT reports that window.
module tb_pll_freq_checker;
   logic clk = 1'b0, rst_n = 1'b0, meas_in = 1'b0, enable = 1'b0;
   logic [15:0] count;
   logic count_valid, led_ok, led_low, led_high, led_dead, led_hb;
   typedef struct {int cnt; bit ok; bit low; bit high; bit dead;} exp_t;
   exp_t sb[$];
   int plan[$];
   int checks = 0, failures = 0, cyc = 0, ph = 0, per = 0, streak = 0, en_cyc = 0;
   bit lat_pending = 0;
   logic exp_hb = 1'b0, prev_cv = 1'b0;
   logic [15:0] last_count = '0;

   pll_freq_checker #(
      .GATE_CYCLES(100), .CNT_W(16), .EXP_MIN(9), .EXP_MAX(11),
      .LOCK_WINDOWS(3), .SETTLE_WINDOWS(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .meas_in(meas_in), .enable(enable),
      .count(count), .count_valid(count_valid), .led_ok(led_ok), .led_low(led_low),
      .led_high(led_high), .led_dead(led_dead), .led_hb(led_hb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint want);
      checks++;
      if (obs !== want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic push(input int p);
      exp_t e;
      int c;
      c = (p == 0) ? 0 : 100 / p;
      streak = (c >= 9 && c <= 11) ? (streak < 3 ? streak + 1 : 3) : 0;
      e.cnt = c; e.ok = streak == 3; e.dead = c == 0; e.low = c > 0 && c < 9; e.high = c > 11;
      sb.push_back(e);
      per = p;
   endtask

   // meas_in is driven 3 ns after each edge; ph restarts at every report so each window
   // sees whole periods, and is forced low in the last cycles so no rise straddles windows
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (count_valid && prev_cv) check("cv_pulse_width", prev_cv, 0);
      prev_cv = count_valid;
      if (count_valid) begin
         if (sb.size() == 0) check("report_when_idle", count_valid, 0);
         else begin
            e = sb.pop_front();
            exp_hb = ~exp_hb;
            if (lat_pending) begin
               check("latency", cyc - en_cyc, 201);
               lat_pending = 0;
            end
            check("count", count, e.cnt);
            check("led_ok", led_ok, e.ok);
            check("led_low", led_low, e.low);
            check("led_high", led_high, e.high);
            check("led_dead", led_dead, e.dead);
            check("led_hb", led_hb, exp_hb);
            last_count = 16'(e.cnt);
            ph = 0;
            if (plan.size() > 0) push(plan.pop_front());
         end
      end
      #2;
      meas_in = per != 0 && ph < 97 && (ph % per) >= per / 2;
      ph = (ph + 1) % 100;
   endtask

   task automatic go();
      streak = 0;
      push(plan.pop_front());
      ph = 0;
      enable = 1'b1;
      en_cyc = cyc;
      lat_pending = 1;
   endtask

   task automatic run();
      int g = 0;
      while (sb.size() > 0 && g < 5000) begin
         step();
         g++;
      end
      check("sb_drained", sb.size(), 0);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_cv"}, count_valid, 0);
      check({tag, "_ok"}, led_ok, 0);
      check({tag, "_low"}, led_low, 0);
      check({tag, "_high"}, led_high, 0);
      check({tag, "_dead"}, led_dead, 0);
   endtask

   initial begin
      repeat (3) step();
      check_quiet("rst");
      check("rst_count", count, 0);
      check("rst_hb", led_hb, 0);
      rst_n = 1'b1;
      step();
      // lock, dead, low, high, then a single bad window inside a locked run
      plan = '{10, 10, 10, 10, 20, 6, 6, 0, 0, 10, 10, 10, 20, 10, 10, 10, 10};
      go();
      run();
      repeat (50) step();
      enable = 1'b0;
      step();
      check_quiet("dis");
      check("dis_count_hold", count, last_count);
      check("dis_hb_hold", led_hb, exp_hb);
      repeat (150) step();
      plan = '{10, 10, 10};
      go();
      run();
      repeat (50) step();
      #2;
      rst_n = 1'b0;
      #1;
      check_quiet("arst");
      check("arst_count", count, 0);
      check("arst_hb", led_hb, 0);
      exp_hb = 1'b0;
      prev_cv = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      plan = '{10, 10, 10};
      go();
      run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
